// File: rtl/async_fifo_wr_arb_if.sv
// Bundle between the producer clients and the FIFO write-port arbiter.
// The master side is the client group; the slave side is the arbiter.
interface async_fifo_wr_arb_if #(
  parameter int NREQ    = 4,
  parameter int D_WIDTH = 8
);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]         req;
  logic [NREQ*D_WIDTH-1:0] req_data;
  logic                    wfull;
  logic [NREQ-1:0]         gnt;
  logic                    winc;
  logic [D_WIDTH-1:0]      wdata;
  logic [OW-1:0]           owner;
  logic                    busy;

  modport master (
    output req, req_data, wfull,
    input  gnt, winc, wdata, owner, busy
  );

  modport slave (
    input  req, req_data, wfull,
    output gnt, winc, wdata, owner, busy
  );
endinterface

// File: rtl/async_fifo_wr_arb.sv
// Round-robin write-port scheduler for the FIFO memory in the wclk domain.
// Owners keep the port for up to MAX_BURST writes; any wfull cycle stalls without granting.
module async_fifo_wr_arb #(
  parameter int NREQ      = 4,
  parameter int D_WIDTH   = 8,
  parameter int MAX_BURST = 4
) (
  input logic               wclk,
  input logic               wrst,
  async_fifo_wr_arb_if.slave bus
);
  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   rrPtr_q, rrPtr_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cntInc;
  logic [NREQ-1:0] gntVec;
  logic [D_WIDTH-1:0] wdataVal;
  logic            winFound;
  logic [OW-1:0]   winIdx;

  function automatic logic [OW-1:0] wrapAdd(input logic [OW-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= NREQ) sum = sum - NREQ;
    return OW'(sum);
  endfunction

  // Cyclic search from rrPtr_q; walking downward lets the closest requester win.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[wrapAdd(rrPtr_q, k)]) begin
        winFound = 1'b1;
        winIdx   = wrapAdd(rrPtr_q, k);
      end
    end
  end

  assign cntInc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    rrPtr_d = rrPtr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gntVec  = '0;
    case (state_q)
      IDLE: begin
        if (!bus.wfull && winFound) begin
          gntVec[winIdx] = 1'b1;
          owner_d        = winIdx;
          cnt_d          = CW'(1);
          if (MAX_BURST > 1) state_d = BURST;
          else               rrPtr_d = wrapAdd(winIdx, 1);
        end
      end
      BURST: begin
        if (bus.req[owner_q]) begin
          if (!bus.wfull) begin
            gntVec[owner_q] = 1'b1;
            cnt_d           = cntInc;
            if (cntInc == CW'(MAX_BURST)) begin
              state_d = IDLE;
              rrPtr_d = wrapAdd(owner_q, 1);
            end
          end
        end else begin
          state_d = IDLE;
          rrPtr_d = wrapAdd(owner_q, 1);
        end
      end
      default: state_d = IDLE;
    endcase
    // No write may leave the block while reset is held, even before the next edge.
    if (wrst) gntVec = '0;
  end

  always_comb begin
    wdataVal = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gntVec[i]) wdataVal = bus.req_data[i*D_WIDTH +: D_WIDTH];
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q <= IDLE;
      rrPtr_q <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rrPtr_q <= rrPtr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt   = gntVec;
  assign bus.winc  = |gntVec;
  assign bus.wdata = wdataVal;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q == BURST) && !wrst;
endmodule
